stage2_exec: RTL and testbench
==============================

Name: stage2_exec

Overview:
- Execute stage (stage 2) of the QLife processor core.
- Resolves the read/write operand from its addressing mode. Drives the RAM read address and computes the ALU result written back to the destination.
- Combinational datapath, plus a clocked zero-flag register consumed by later conditional-branch logic.

Parameters:
- DATA_W, 32, operand/ALU width
- ADDR_W, 16, RAM address width (equals PC width)

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous active-high reset
- mblock_s2  input  3  operand addressing-mode select
- vr_source  input  8  raw byte of read-operand field (high address byte)
- vr_value  input  32  resolved read-operand value
- vrw_source  input  8  raw byte of read/write-operand field (low address byte)
- alu_op  input  4  ALU operation select
- pc  input  16  current program counter
- ram_value  input  32  RAM read data at ram_address (combinational)
- flag_update  input  1  latch alu_is_zero into zero_flag on next clk edge
- vrw_value  output  32  resolved read/write-operand value
- vw_value  output  32  ALU result (value to write back)
- ram_address  output  16  RAM read address
- alu_is_zero  output  1  vw_value == 0 (combinational)
- zero_flag  output  1  registered zero flag

Behaviour:
- All outputs except zero_flag are purely combinational; they settle within the same cycle and do not depend on clk or reset.
- mblock_s2 decode (zext = zero-extend):
  - 0: ram_address = zext(vrw_source); vrw_value = ram_value
  - 1: ram_address = vr_value[15:0]; vrw_value = ram_value
  - 2: ram_address = {vr_source, vrw_source}; vrw_value = ram_value
  - 3 (reserved): ram_address = 0; vrw_value = 0
  - 4: vrw_value = zext(vrw_source)
  - 5 (reserved): vrw_value = 0
  - 6: vrw_value = zext({vr_source, vrw_source})
  - 7: vrw_value = zext(pc)
  - For modes 4-7, ram_address = zext(vrw_source); the value is don't-care to consumers but must be driven, never X.
- ALU: vw_value = vrw_value OP vr_value. All results are 32-bit and wrap modulo 2^32, with no carry or overflow outputs.
  - 0 ADD: vrw + vr
  - 1 SUB: vrw - vr
  - 2 SHL: vrw << vr[4:0]
  - 3 SHR (logical): vrw >> vr[4:0]
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 PASS_A: vrw
  - 8 PASS_B: vr
  - 9 NOT: ~vrw
  - 10-15 (reserved): result 0
- alu_is_zero = (vw_value == 32'h0). Reserved ops therefore assert alu_is_zero.
- zero_flag:
  - reset high (async) forces 0 immediately and holds 0 while asserted.
  - On posedge clk with reset low and flag_update=1: zero_flag <= alu_is_zero.
  - Otherwise zero_flag holds.
  - If reset deasserts coincident with a clk edge, reset wins for that edge.
- No X propagation: every case of mblock_s2 and alu_op drives a defined value.

Test Plan:
- Modes 0/1/2, vr_source=10, vr_value=1000, vrw_source=20, pc=84, ram_value=99, ADD:
  - mode 0 -> ram_address=20, vrw_value=99, vw_value=1099, alu_is_zero=0
  - mode 1 -> ram_address=1000, vrw_value=99, vw_value=1099, alu_is_zero=0
  - mode 2 -> ram_address=2580 (0x0A14), vrw_value=99, vw_value=1099, alu_is_zero=0
- Immediates, same inputs:
  - mode 4 -> vrw_value=20, vw_value=1020
  - mode 6 -> vrw_value=2580, vw_value=3580
  - mode 7 -> vrw_value=84, vw_value=1084
  - alu_is_zero=0 in all three cases
- Zero result: mode 0, SUB, ram_value=1000, vr_value=1000 -> vrw_value=1000, ram_address=20, vw_value=0, alu_is_zero=1.
- ALU sweep: vrw=0xF0F0_0001, vr=4:
  - SHL -> 0x0F00_0010
  - SHR -> 0x0F0F_0000
  - AND -> 0
  - XOR -> 0xF0F0_0005
  - SUB with vr > vrw wraps (vrw=1, vr=2 -> 0xFFFF_FFFF)
  - reserved op 12 -> 0, alu_is_zero=1
- Reserved modes 3 and 5 -> vrw_value=0. Mode 3 -> ram_address=0. No X on any output for all 8 modes x 16 ops.
- zero_flag:
  - reset pulse mid-operation -> 0 asynchronously
  - with flag_update=1 and alu_is_zero=1, after clk edge -> 1
  - flag_update=0 with alu_is_zero toggling over 3 clocks -> holds 1
  - reset -> 0

Source files
------------

// File: rtl/stage2_exec.sv
// QLife execute stage: resolves the read/write operand, drives the RAM read
// address, computes the ALU result and keeps a registered zero flag.
module stage2_exec #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mblock_s2,
    input  logic [7:0]        vr_source,
    input  logic [DATA_W-1:0] vr_value,
    input  logic [7:0]        vrw_source,
    input  logic [3:0]        alu_op,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] ram_value,
    input  logic              flag_update,
    output logic [DATA_W-1:0] vrw_value,
    output logic [DATA_W-1:0] vw_value,
    output logic [ADDR_W-1:0] ram_address,
    output logic              alu_is_zero,
    output logic              zero_flag
);

    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SHL    = 4'd2,
        OP_SHR    = 4'd3,
        OP_AND    = 4'd4,
        OP_OR     = 4'd5,
        OP_XOR    = 4'd6,
        OP_PASS_A = 4'd7,
        OP_PASS_B = 4'd8,
        OP_NOT    = 4'd9
    } alu_op_e;

    logic [SH_W-1:0]   w_shamt;
    logic [15:0]       w_abs_addr;
    logic              r_zero_flag;

    assign w_shamt    = vr_value[SH_W-1:0];
    assign w_abs_addr = {vr_source, vrw_source};

    // Operand resolution: modes 0-3 read RAM, modes 4-7 are immediates.
    always_comb begin
        ram_address = ADDR_W'(vrw_source);
        vrw_value   = '0;
        case (mblock_s2)
            3'd0: vrw_value = ram_value;
            3'd1: begin
                ram_address = vr_value[ADDR_W-1:0];
                vrw_value   = ram_value;
            end
            3'd2: begin
                ram_address = ADDR_W'(w_abs_addr);
                vrw_value   = ram_value;
            end
            3'd3: ram_address = '0;
            3'd4: vrw_value = DATA_W'(vrw_source);
            3'd6: vrw_value = DATA_W'(w_abs_addr);
            3'd7: vrw_value = DATA_W'(pc);
            default: vrw_value = '0;
        endcase
    end

    always_comb begin
        vw_value = '0;
        case (alu_op_e'(alu_op))
            OP_ADD:    vw_value = vrw_value + vr_value;
            OP_SUB:    vw_value = vrw_value - vr_value;
            OP_SHL:    vw_value = vrw_value << w_shamt;
            OP_SHR:    vw_value = vrw_value >> w_shamt;
            OP_AND:    vw_value = vrw_value & vr_value;
            OP_OR:     vw_value = vrw_value | vr_value;
            OP_XOR:    vw_value = vrw_value ^ vr_value;
            OP_PASS_A: vw_value = vrw_value;
            OP_PASS_B: vw_value = vr_value;
            OP_NOT:    vw_value = ~vrw_value;
            default:   vw_value = '0;
        endcase
    end

    assign alu_is_zero = (vw_value == '0);

    // Zero flag is sampled only when the instruction asks for a flag update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero_flag <= 1'b0;
        end else if (flag_update) begin
            r_zero_flag <= alu_is_zero;
        end
    end

    assign zero_flag = r_zero_flag;

endmodule

// File: tb/tb_stage2_exec.sv
// Directed self-checking bench for stage2_exec.
module tb_stage2_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mblock_s2;
    logic [7:0]  vr_source;
    logic [31:0] vr_value;
    logic [7:0]  vrw_source;
    logic [3:0]  alu_op;
    logic [15:0] pc;
    logic [31:0] ram_value;
    logic        flag_update;
    logic [31:0] vrw_value;
    logic [31:0] vw_value;
    logic [15:0] ram_address;
    logic        alu_is_zero;
    logic        zero_flag;

    int checks = 0;
    int errors = 0;
    int xcount;

    stage2_exec #(.DATA_W(32), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .mblock_s2(mblock_s2), .vr_source(vr_source),
        .vr_value(vr_value), .vrw_source(vrw_source), .alu_op(alu_op), .pc(pc),
        .ram_value(ram_value), .flag_update(flag_update), .vrw_value(vrw_value),
        .vw_value(vw_value), .ram_address(ram_address), .alu_is_zero(alu_is_zero),
        .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] m, input logic [3:0] op,
                         input logic [31:0] vr, input logic [31:0] ram);
        mblock_s2 = m;
        alu_op    = op;
        vr_value  = vr;
        ram_value = ram;
        #1;
    endtask

    initial begin
        reset = 1'b1; flag_update = 1'b0;
        mblock_s2 = 3'd0; alu_op = 4'd0; vr_source = 8'd10; vr_value = 32'd1000;
        vrw_source = 8'd20; pc = 16'd84; ram_value = 32'd99;
        #2;
        chk("reset_zero_flag", {31'd0, zero_flag}, 32'd0);

        // Memory modes, ADD
        drive(3'd0, 4'd0, 32'd1000, 32'd99);
        chk("m0_addr", {16'd0, ram_address}, 32'd20);
        chk("m0_vrw", vrw_value, 32'd99);
        chk("m0_vw", vw_value, 32'd1099);
        chk("m0_zero", {31'd0, alu_is_zero}, 32'd0);
        drive(3'd1, 4'd0, 32'd1000, 32'd99);
        chk("m1_addr", {16'd0, ram_address}, 32'd1000);
        chk("m1_vrw", vrw_value, 32'd99);
        chk("m1_vw", vw_value, 32'd1099);
        drive(3'd2, 4'd0, 32'd1000, 32'd99);
        chk("m2_addr", {16'd0, ram_address}, 32'h0A14);
        chk("m2_vrw", vrw_value, 32'd99);
        chk("m2_vw", vw_value, 32'd1099);
        chk("m2_zero", {31'd0, alu_is_zero}, 32'd0);

        // Immediate modes
        drive(3'd4, 4'd0, 32'd1000, 32'd99);
        chk("m4_vrw", vrw_value, 32'd20);
        chk("m4_vw", vw_value, 32'd1020);
        chk("m4_addr", {16'd0, ram_address}, 32'd20);
        chk("m4_zero", {31'd0, alu_is_zero}, 32'd0);
        drive(3'd6, 4'd0, 32'd1000, 32'd99);
        chk("m6_vrw", vrw_value, 32'd2580);
        chk("m6_vw", vw_value, 32'd3580);
        chk("m6_zero", {31'd0, alu_is_zero}, 32'd0);
        drive(3'd7, 4'd0, 32'd1000, 32'd99);
        chk("m7_vrw", vrw_value, 32'd84);
        chk("m7_vw", vw_value, 32'd1084);
        chk("m7_zero", {31'd0, alu_is_zero}, 32'd0);

        // Reserved modes
        drive(3'd3, 4'd0, 32'd1000, 32'd99);
        chk("m3_vrw", vrw_value, 32'd0);
        chk("m3_addr", {16'd0, ram_address}, 32'd0);
        chk("m3_vw", vw_value, 32'd1000);
        drive(3'd5, 4'd0, 32'd1000, 32'd99);
        chk("m5_vrw", vrw_value, 32'd0);
        chk("m5_addr", {16'd0, ram_address}, 32'd20);

        // Zero result
        drive(3'd0, 4'd1, 32'd1000, 32'd1000);
        chk("sub0_vrw", vrw_value, 32'd1000);
        chk("sub0_addr", {16'd0, ram_address}, 32'd20);
        chk("sub0_vw", vw_value, 32'd0);
        chk("sub0_zero", {31'd0, alu_is_zero}, 32'd1);

        // ALU sweep with vrw = 0xF0F00001 via mode 1, vr = 4
        drive(3'd1, 4'd2, 32'd4, 32'hF0F0_0001);
        chk("shl", vw_value, 32'h0F00_0010);
        drive(3'd1, 4'd2, 32'd36, 32'hF0F0_0001);
        chk("shl_amt_wrap", vw_value, 32'h0F00_0010);
        drive(3'd1, 4'd3, 32'd4, 32'hF0F0_0001);
        chk("shr", vw_value, 32'h0F0F_0000);
        drive(3'd1, 4'd4, 32'd4, 32'hF0F0_0001);
        chk("and", vw_value, 32'h0);
        chk("and_zero", {31'd0, alu_is_zero}, 32'd1);
        drive(3'd1, 4'd5, 32'd4, 32'hF0F0_0001);
        chk("or", vw_value, 32'hF0F0_0005);
        drive(3'd1, 4'd6, 32'd4, 32'hF0F0_0001);
        chk("xor", vw_value, 32'hF0F0_0005);
        drive(3'd1, 4'd7, 32'd4, 32'hF0F0_0001);
        chk("pass_a", vw_value, 32'hF0F0_0001);
        drive(3'd1, 4'd8, 32'd4, 32'hF0F0_0001);
        chk("pass_b", vw_value, 32'd4);
        drive(3'd1, 4'd9, 32'd4, 32'hF0F0_0001);
        chk("not", vw_value, 32'h0F0F_FFFE);
        drive(3'd1, 4'd0, 32'd4, 32'hFFFF_FFFE);
        chk("add_wrap", vw_value, 32'h2);
        drive(3'd1, 4'd1, 32'd2, 32'd1);
        chk("sub_wrap", vw_value, 32'hFFFF_FFFF);
        chk("sub_wrap_zero", {31'd0, alu_is_zero}, 32'd0);
        drive(3'd1, 4'd12, 32'd4, 32'hF0F0_0001);
        chk("op12", vw_value, 32'd0);
        chk("op12_zero", {31'd0, alu_is_zero}, 32'd1);

        // No X on any output across all modes and ops
        xcount = 0;
        for (int m = 0; m < 8; m++) begin
            for (int op = 0; op < 16; op++) begin
                drive(m[2:0], op[3:0], 32'h1234_5678, 32'h9ABC_DEF0);
                if ($isunknown({vrw_value, vw_value, ram_address, alu_is_zero, zero_flag}))
                    xcount++;
            end
        end
        chk("no_x_sweep", xcount, 32'd0);

        // Zero flag: reset held across an edge keeps 0
        @(negedge clk);
        drive(3'd0, 4'd1, 32'd1000, 32'd1000);
        flag_update = 1'b1;
        @(posedge clk); #1;
        chk("zf_reset_held", {31'd0, zero_flag}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("zf_set", {31'd0, zero_flag}, 32'd1);

        // Async reset pulse mid-cycle
        #2 reset = 1'b1;
        #1;
        chk("zf_async_rst", {31'd0, zero_flag}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("zf_reset_again", {31'd0, zero_flag}, 32'd1);

        // Hold with flag_update low while alu_is_zero toggles
        @(negedge clk);
        flag_update = 1'b0;
        drive(3'd0, 4'd0, 32'd1000, 32'd99);
        @(posedge clk); #1;
        chk("zf_hold1", {31'd0, zero_flag}, 32'd1);
        @(negedge clk);
        drive(3'd0, 4'd1, 32'd1000, 32'd1000);
        @(posedge clk); #1;
        chk("zf_hold2", {31'd0, zero_flag}, 32'd1);
        @(negedge clk);
        drive(3'd0, 4'd0, 32'd1000, 32'd99);
        @(posedge clk); #1;
        chk("zf_hold3", {31'd0, zero_flag}, 32'd1);

        // Update with non-zero result clears the flag
        @(negedge clk);
        flag_update = 1'b1;
        @(posedge clk); #1;
        chk("zf_clear", {31'd0, zero_flag}, 32'd0);
        @(negedge clk);
        drive(3'd0, 4'd1, 32'd1000, 32'd1000);
        @(posedge clk); #1;
        chk("zf_set2", {31'd0, zero_flag}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("zf_final_rst", {31'd0, zero_flag}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
